// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the memory stream arbiter.
//   state_e       - arbiter FSM states
//   GRANT_*       - encoding of the last contended grant
//   *_DEF         - default parameter values for the top level
package mem_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WR_ACC  = 2'd1,
      S_RD_ACC  = 2'd2,
      S_RECOVER = 2'd3
   } state_e;

   localparam logic GRANT_READ  = 1'b0;
   localparam logic GRANT_WRITE = 1'b1;

   localparam int ADDR_WIDTH_DEF = 18;
   localparam int MEM_WAIT_DEF   = 3;

endpackage

// File: rtl/edge_sync.sv
// edge_sync: two-flop synchronizer for a level from a foreign clock domain,
// followed by a rising-edge detector producing a one-cycle pulse.
//   clk_i   - destination clock
//   rst_ni  - asynchronous active-low reset
//   d_i     - asynchronous level input
//   rise_o  - one-cycle pulse after a synchronized 0->1 transition
module edge_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic rise_o
);

   logic s1_q, s2_q, s3_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   // s3 is only a history flop for edge detection, not a third sync stage
   assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/mem_stream_arbiter.sv
// mem_stream_arbiter: owns the external 16-bit memory port and shares it
// between the sensor logger (writes) and the downlink unpacker (reads). The
// memory is used as a circular buffer; one slot is always left unused.
//   CLK_48MHZ, RESET          - clock, asynchronous active-low reset
//   WR_REQ/WR_DATA/WR_ACK     - logger write request, data, completion pulse
//   RD_CMD                    - unpacker read command level (foreign domain)
//   RD_DATA/RD_VALID          - last word read, update pulse
//   MEM_*                     - memory address, data and active-low strobes
//   EMPTY/FULL/OVERRUN        - buffer status, sticky word-lost flag
module mem_stream_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int MEM_WAIT   = MEM_WAIT_DEF
) (
   input  logic                  CLK_48MHZ,
   input  logic                  RESET,
   input  logic                  WR_REQ,
   input  logic [15:0]           WR_DATA,
   output logic                  WR_ACK,
   input  logic                  RD_CMD,
   output logic [15:0]           RD_DATA,
   output logic                  RD_VALID,
   output logic [ADDR_WIDTH-1:0] MEM_ADDR,
   output logic [15:0]           MEM_DOUT,
   input  logic [15:0]           MEM_DIN,
   output logic                  MEM_CE_N,
   output logic                  MEM_WE_N,
   output logic                  MEM_OE_N,
   output logic                  EMPTY,
   output logic                  FULL,
   output logic                  OVERRUN
);

   localparam logic [3:0] WAIT_LD = 4'(MEM_WAIT - 1);

   state_e                state_q;
   logic [3:0]            cnt_q;
   logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
   logic                  wr_pend_q, rd_pend_q, last_grant_q, overrun_q;
   logic [15:0]           wr_hold_q, dout_q, rd_data_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  ce_n_q, we_n_q, oe_n_q, rd_valid_q, wr_ack_q;
   logic                  rd_rise, rd_elig, conflict, grant_wr, grant_rd;

   edge_sync u_rd_sync (
      .clk_i  (CLK_48MHZ),
      .rst_ni (RESET),
      .d_i    (RD_CMD),
      .rise_o (rd_rise)
   );

   assign wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
   assign rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
   assign EMPTY    = (wr_ptr_q == rd_ptr_q);
   assign FULL     = (wr_ptr_d == rd_ptr_q);

   // A read waits (stays pending) while the buffer is empty.
   assign rd_elig  = rd_pend_q & ~EMPTY;
   assign conflict = wr_pend_q & rd_elig;
   assign grant_wr = wr_pend_q & (~rd_elig | (last_grant_q == GRANT_READ));
   assign grant_rd = rd_elig & (~wr_pend_q | (last_grant_q == GRANT_WRITE));

   always_ff @(posedge CLK_48MHZ or negedge RESET) begin
      if (!RESET) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         wr_pend_q    <= 1'b0;
         rd_pend_q    <= 1'b0;
         last_grant_q <= GRANT_READ;
         overrun_q    <= 1'b0;
         wr_hold_q    <= '0;
         dout_q       <= '0;
         rd_data_q    <= '0;
         addr_q       <= '0;
         ce_n_q       <= 1'b1;
         we_n_q       <= 1'b1;
         oe_n_q       <= 1'b1;
         rd_valid_q   <= 1'b0;
         wr_ack_q     <= 1'b0;
      end else begin
         wr_ack_q   <= 1'b0;
         rd_valid_q <= 1'b0;

         // Request capture; the FSM below may clear pend flags afterwards.
         if (WR_REQ) begin
            if (wr_pend_q) begin
               overrun_q <= 1'b1;
            end else begin
               wr_pend_q <= 1'b1;
               wr_hold_q <= WR_DATA;
            end
         end
         if (rd_rise) rd_pend_q <= 1'b1;

         case (state_q)
            S_IDLE: begin
               if (grant_wr) begin
                  if (conflict) last_grant_q <= GRANT_WRITE;
                  if (FULL) begin
                     // No memory cycle: drop the word but still acknowledge it.
                     wr_ack_q  <= 1'b1;
                     wr_pend_q <= 1'b0;
                     overrun_q <= 1'b1;
                  end else begin
                     state_q <= S_WR_ACC;
                     addr_q  <= wr_ptr_q;
                     dout_q  <= wr_hold_q;
                     ce_n_q  <= 1'b0;
                     we_n_q  <= 1'b0;
                     cnt_q   <= WAIT_LD;
                  end
               end else if (grant_rd) begin
                  if (conflict) last_grant_q <= GRANT_READ;
                  state_q <= S_RD_ACC;
                  addr_q  <= rd_ptr_q;
                  ce_n_q  <= 1'b0;
                  oe_n_q  <= 1'b0;
                  cnt_q   <= WAIT_LD;
               end
            end
            S_WR_ACC: begin
               if (cnt_q == 4'd0) begin
                  state_q   <= S_RECOVER;
                  ce_n_q    <= 1'b1;
                  we_n_q    <= 1'b1;
                  wr_ack_q  <= 1'b1;
                  wr_ptr_q  <= wr_ptr_d;
                  wr_pend_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_RD_ACC: begin
               if (cnt_q == 4'd0) begin
                  state_q    <= S_RECOVER;
                  ce_n_q     <= 1'b1;
                  oe_n_q     <= 1'b1;
                  rd_data_q  <= MEM_DIN;
                  rd_valid_q <= 1'b1;
                  rd_ptr_q   <= rd_ptr_d;
                  rd_pend_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_RECOVER: state_q <= S_IDLE;
            default:   state_q <= S_IDLE;
         endcase
      end
   end

   assign WR_ACK   = wr_ack_q;
   assign RD_DATA  = rd_data_q;
   assign RD_VALID = rd_valid_q;
   assign MEM_ADDR = addr_q;
   assign MEM_DOUT = dout_q;
   assign MEM_CE_N = ce_n_q;
   assign MEM_WE_N = we_n_q;
   assign MEM_OE_N = oe_n_q;
   assign OVERRUN  = overrun_q;

endmodule
